// File: rtl/sa_pkg.sv
// Shared widths, the controller state type and a width helper for the
// systolic-array tile controller.
package sa_pkg;
    localparam int ROWS_DEF = 8;
    localparam int OPND_W   = 8;
    localparam int RES_W    = 32;
    localparam int CNT_W    = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FEED    = 3'd1,
        FLUSH   = 3'd2,
        WAITRES = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } sa_ctrl_state_t;

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction
endpackage

// File: rtl/sa_ctrl_if.sv
// Command, operand-stream, array and result-stream signals of sa_ctrl.
// The slave modport is the controller; master is whatever drives it.
interface sa_ctrl_if #(
    parameter int ROWS = sa_pkg::ROWS_DEF
);
    import sa_pkg::*;

    localparam int RW = row_w(ROWS);

    logic                          start;
    logic [CNT_W-1:0]              cfg_k;
    logic                          abort;
    logic                          busy;
    logic                          done;
    logic                          err;

    // opnd_* and res_* are valid/ready streams: a transfer happens on a rising
    // edge where valid && ready; the producer holds its payload stable while
    // valid && !ready.
    logic                          opnd_valid;
    logic                          opnd_ready;
    logic [ROWS-1:0][OPND_W-1:0]   opnd_a;
    logic [ROWS-1:0][OPND_W-1:0]   opnd_w;

    logic [ROWS-1:0][OPND_W-1:0]   ainport;
    logic [ROWS-1:0][OPND_W-1:0]   winport;
    logic                          inpvalid;
    logic                          outread;
    logic [ROWS-1:0][RES_W-1:0]    routport;
    logic [ROWS-1:0]               rvalidport;

    logic                          res_valid;
    logic                          res_ready;
    logic [RES_W-1:0]              res_data;
    logic [RW-1:0]                 res_row;

    modport slave (
        input  start, cfg_k, abort, opnd_valid, opnd_a, opnd_w,
               routport, rvalidport, res_ready,
        output busy, done, err, opnd_ready, ainport, winport,
               inpvalid, outread, res_valid, res_data, res_row
    );

    modport master (
        output start, cfg_k, abort, opnd_valid, opnd_a, opnd_w,
               routport, rvalidport, res_ready,
        input  busy, done, err, opnd_ready, ainport, winport,
               inpvalid, outread, res_valid, res_data, res_row
    );
endinterface

// File: rtl/sa_ctrl_drain.sv
// Captures one full set of array results and serialises it row by row
// onto the result stream.
module sa_ctrl_drain
    import sa_pkg::*;
#(
    parameter int ROWS = ROWS_DEF
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       active_i,
    input  logic                       capture_i,
    input  logic                       accept_i,
    input  logic [ROWS-1:0][RES_W-1:0] rout_i,
    output logic                       res_valid_o,
    output logic [RES_W-1:0]           res_data_o,
    output logic [row_w(ROWS)-1:0]     res_row_o,
    output logic                       last_o
);
    localparam int RW = row_w(ROWS);
    localparam logic [RW-1:0] IDX_LAST = RW'(ROWS - 1);

    logic [ROWS-1:0][RES_W-1:0] rbuf_q;
    logic [RW-1:0]              idx_q;

    // Capture always restarts the serialiser at row 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rbuf_q <= '0;
            idx_q  <= '0;
        end else if (capture_i) begin
            rbuf_q <= rout_i;
            idx_q  <= '0;
        end else if (accept_i) begin
            idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + RW'(1);
        end
    end

    assign last_o      = accept_i && (idx_q == IDX_LAST);
    assign res_valid_o = active_i;
    assign res_data_o  = rbuf_q[idx_q];
    assign res_row_o   = idx_q;
endmodule

// File: rtl/sa_ctrl.sv
// Tile controller for a ROWS x ROWS systolic array: feeds k operand beats,
// waits out the skew flush, collects the results and streams them out.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int FLUSH_CYC = 2 * ROWS - 1
) (
    input  logic           clk,
    input  logic           rstn,
    sa_ctrl_if.slave       bus,
    output sa_ctrl_state_t state_o
);
    localparam int FLW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FLW-1:0] FL_LAST = FLW'(FLUSH_CYC - 1);

    sa_ctrl_state_t              state_q, state_d;
    logic [CNT_W-1:0]            k_q, k_d;
    logic [CNT_W-1:0]            beat_q, beat_d;
    logic [FLW-1:0]              fl_q, fl_d;
    logic                        err_q, err_d;
    logic [ROWS-1:0][OPND_W-1:0] a_q, w_q;
    logic                        inpvalid_q, outread_q;

    logic busy_w;
    logic abort_act;
    logic beat_acc;
    logic capture;
    logic drain_acc;
    logic drain_last;

    assign busy_w    = (state_q != IDLE) && (state_q != DONE);
    assign abort_act = bus.abort && busy_w;

    // An abort in the same cycle as a handshake cancels that transfer.
    assign beat_acc  = (state_q == FEED)    && bus.opnd_valid   && !bus.abort;
    assign capture   = (state_q == WAITRES) && (&bus.rvalidport) && !bus.abort;
    assign drain_acc = (state_q == DRAIN)   && bus.res_ready    && !bus.abort;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        fl_d    = fl_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_k != '0) begin
                        state_d = FEED;
                        k_d     = bus.cfg_k;
                        beat_d  = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            FEED: begin
                if (beat_acc) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_d == k_q) begin
                        state_d = FLUSH;
                        fl_d    = '0;
                    end
                end
            end
            FLUSH: begin
                if (fl_q == FL_LAST) begin
                    state_d = WAITRES;
                end else begin
                    fl_d = fl_q + FLW'(1);
                end
            end
            WAITRES: begin
                if (capture) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_act) begin
            state_d = DONE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            k_q        <= '0;
            beat_q     <= '0;
            fl_q       <= '0;
            err_q      <= 1'b0;
            a_q        <= '0;
            w_q        <= '0;
            inpvalid_q <= 1'b0;
            outread_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            beat_q     <= beat_d;
            fl_q       <= fl_d;
            err_q      <= err_d;
            inpvalid_q <= beat_acc;
            outread_q  <= capture;
            if (beat_acc) begin
                a_q <= bus.opnd_a;
                w_q <= bus.opnd_w;
            end
        end
    end

    sa_ctrl_drain #(
        .ROWS(ROWS)
    ) u_drain (
        .clk        (clk),
        .rstn       (rstn),
        .active_i   (state_q == DRAIN),
        .capture_i  (capture),
        .accept_i   (drain_acc),
        .rout_i     (bus.routport),
        .res_valid_o(bus.res_valid),
        .res_data_o (bus.res_data),
        .res_row_o  (bus.res_row),
        .last_o     (drain_last)
    );

    assign bus.busy       = busy_w;
    assign bus.done       = (state_q == DONE);
    assign bus.err        = (state_q == DONE) && err_q;
    assign bus.opnd_ready = (state_q == FEED);
    assign bus.ainport    = a_q;
    assign bus.winport    = w_q;
    assign bus.inpvalid   = inpvalid_q;
    assign bus.outread    = outread_q;
    assign state_o        = state_q;
endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter ROWS, default 8: systolic array rows/columns driven by this controller.
REQ-002 Parameter FLUSH_CYC, default 2*ROWS-1: idle cycles after the last input beat that let skewed operands propagate through the array.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; launches a tile when the block is idle.
REQ-006 cfg_k  input  8  accumulation beats per tile; sampled on accepted start.
REQ-007 abort  input  1  cancels the current tile.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle pulse at tile completion.
REQ-010 err  output  1  high with done when the tile was rejected or aborted.
REQ-011 opnd_valid / opnd_ready  input / output  1 / 1  operand stream handshake.
REQ-012 opnd_a, opnd_w  input  ROWS x 8 each  activation and weight vectors of one beat.
REQ-013 ainport, winport  output  ROWS x 8 each  array operand ports.
REQ-014 inpvalid  output  1  array input-valid.
REQ-015 outread  output  1  array result-read strobe.
REQ-016 routport  input  ROWS x 32  array results.
REQ-017 rvalidport  input  ROWS  per-row result-valid.
REQ-018 res_valid / res_ready  output / input  1 / 1  result stream handshake.
REQ-019 res_data, res_row  output  32 / clog2(ROWS)  result value and its row index.

Function
REQ-020 The FSM SHALL have states IDLE, FEED, FLUSH, WAITRES, DRAIN, DONE.
REQ-021 IDLE: start with cfg_k!=0 -> FEED, latch cfg_k, zero beat counter; start with cfg_k==0 -> DONE with err=1; start while busy is ignored.
REQ-022 FEED: opnd_ready=1; each opnd_valid&&opnd_ready beat registers opnd_a/opnd_w onto ainport/winport and asserts inpvalid exactly one cycle later (latency 1).
REQ-023 inpvalid SHALL be 0 in every cycle that does not follow an accepted beat, including opnd_valid bubbles.
REQ-024 After beat cfg_k is accepted, opnd_ready drops in the same cycle and the state -> FLUSH; the beat counter is 8 bits and never wraps (max 255).
REQ-025 FLUSH: inpvalid=0 for FLUSH_CYC cycles, then -> WAITRES.
REQ-026 WAITRES: when rvalidport is all ones, capture all routport rows into an internal ROWS x 32 buffer, pulse outread for exactly one cycle, and -> DRAIN.
REQ-027 DRAIN: present rows 0..ROWS-1 in order on res_data/res_row with res_valid=1; advance on res_valid&&res_ready; res_data/res_row SHALL hold stable while res_ready=0.
REQ-028 After row ROWS-1 is accepted -> DONE; DONE asserts done for one cycle (err=0 on normal completion) and -> IDLE.
REQ-029 abort in FEED/FLUSH/WAITRES/DRAIN: next cycle inpvalid=0, opnd_ready=0, res_valid=0, state DONE with err=1; abort in IDLE or DONE has no effect.
REQ-030 When abort and a handshake occur in the same cycle, abort wins; that beat/row is counted as not consumed.
REQ-031 busy = (state != IDLE) && (state != DONE).

Reset
REQ-032 On a rstn=0 sampled at a clock edge: state IDLE; busy, done, err, inpvalid, outread, opnd_ready, res_valid = 0; ainport, winport, res_data, res_row, counters, buffer = 0.
REQ-033 Reset mid-tile SHALL discard all progress with no done pulse; the first start after release is accepted normally.

Structure
REQ-034 Package sa_pkg holds ROWS default, the 8-bit operand and 32-bit result widths, and the sa_ctrl_state_t enum.
REQ-035 Result capture buffer plus DRAIN serializer SHALL be a sub-module sa_ctrl_drain; FSM, feed path and counters stay in sa_ctrl.

Verification
REQ-036 cfg_k=4, opnd_valid always 1, array model sets all rvalidport 3 cycles after FLUSH -> 4 inpvalid cycles, 15 flush cycles, one outread pulse, 8 results rows 0..7, done with err=0.
REQ-037 cfg_k=3 with opnd_valid low on alternate cycles -> exactly 3 inpvalid pulses, each 1 cycle after its beat; ainport values match the beats in order.
REQ-038 DRAIN with res_ready toggling 1,0,0,1... -> no row lost or duplicated; res_data stable while stalled.
REQ-039 start with cfg_k=0 -> no inpvalid, done and err both high next cycle, busy never high.
REQ-040 abort in the 2nd FEED beat, then rstn low 1 cycle during a second tile's DRAIN -> first: done+err, inpvalid 0 next cycle; second: all outputs 0, no done, next start with cfg_k=2 completes normally.
